vertex_stream_sequencer: RTL and testbench

Drives the projection engine's start/done handshake from the initiator side. On each frame it requests an MVP matrix update, then fetches each model-space vertex from vertex memory, issues one transform per vertex, and collects the resulting screen coordinates. Results are pushed into a small output FIFO that feeds the line rasterizer, with a clip flag and an end-of-frame marker.

---
 rtl/vertex_stream_sequencer_if.sv | 66 ++++++
 rtl/vertex_stream_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vertex_stream_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vertex_stream_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : vertex_stream_sequencer_if
// Purpose  : Bundles the frame control, vertex memory, projection engine and
//            rasterizer FIFO signals of the vertex stream sequencer.
// Modports : master - the sequencer (drives busy/frame_done, vert_rd/addr,
//                     mvp_start/update/x/y/z, out_* head signals)
//            slave  - the surrounding system (frame control, vertex memory,
//                     projection engine, rasterizer consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface vertex_stream_sequencer_if #(
  parameter int ADDR_W = 8
);
  // Frame control
  logic              frame_start;
  logic [ADDR_W-1:0] vert_count;
  logic              busy;
  logic              frame_done;
  // Vertex memory
  logic              vert_rd;
  logic [ADDR_W-1:0] vert_addr;
  logic [31:0]       vert_x;
  logic [31:0]       vert_y;
  logic [31:0]       vert_z;
  // Projection engine
  logic              mvp_start;
  logic              mvp_update;
  logic [31:0]       mvp_x;
  logic [31:0]       mvp_y;
  logic [31:0]       mvp_z;
  logic              mvp_done;
  logic [31:0]       mvp_ox;
  logic [31:0]       mvp_oy;
  logic [31:0]       mvp_oz;
  // Rasterizer output FIFO
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_sx;
  logic [15:0]       out_sy;
  logic              out_clip;
  logic              out_last;

  modport master (
    input  frame_start, vert_count,
    output busy, frame_done,
    output vert_rd, vert_addr,
    input  vert_x, vert_y, vert_z,
    output mvp_start, mvp_update, mvp_x, mvp_y, mvp_z,
    input  mvp_done, mvp_ox, mvp_oy, mvp_oz,
    output out_valid, out_sx, out_sy, out_clip, out_last,
    input  out_ready
  );

  modport slave (
    output frame_start, vert_count,
    input  busy, frame_done,
    input  vert_rd, vert_addr,
    output vert_x, vert_y, vert_z,
    input  mvp_start, mvp_update, mvp_x, mvp_y, mvp_z,
    output mvp_done, mvp_ox, mvp_oy, mvp_oz,
    input  out_valid, out_sx, out_sy, out_clip, out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/vertex_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vertex_stream_sequencer
// Purpose  : Per frame: requests an MVP matrix update from the projection
//            engine, then fetches each vertex from vertex memory, issues one
//            transform per vertex and pushes the screen coordinates (with a
//            clip flag and an end-of-frame marker) into a small output FIFO
//            feeding the line rasterizer.
// Ports    : clock   - system clock, all logic on posedge
//            reset_n - asynchronous active-low reset
//            bus     - vertex_stream_sequencer_if.master (frame control,
//                      vertex memory, engine handshake, output FIFO head)
// Params   : ADDR_W     - vertex address width / vert_count width
//            FIFO_DEPTH - output FIFO entries (power of two, >= 2)
// Revision : 1.0 - initial release
// ============================================================================
module vertex_stream_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic                  clock,
  input  wire logic                  reset_n,
  vertex_stream_sequencer_if.master  bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_UPD_ISSUE = 4'd1;
  localparam logic [3:0] S_UPD_WAIT  = 4'd2;
  localparam logic [3:0] S_FETCH     = 4'd3;
  localparam logic [3:0] S_FW1       = 4'd4;
  localparam logic [3:0] S_FW2       = 4'd5;
  localparam logic [3:0] S_XF_ISSUE  = 4'd6;
  localparam logic [3:0] S_XF_WAIT   = 4'd7;
  localparam logic [3:0] S_PUSH      = 4'd8;
  localparam logic [3:0] S_FINISH    = 4'd9;

  // FIFO geometry; an entry is {sx[15:0], sy[15:0], clip, last}
  localparam int             PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int             CNT_W       = PTR_W + 1;
  localparam int             ENTRY_W     = 34;
  localparam logic [CNT_W-1:0] C_FIFO_FULL = CNT_W'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [3:0]         r_state;
  logic [3:0]         w_state_nxt;

  logic [ADDR_W-1:0]  r_count;
  logic [ADDR_W-1:0]  r_idx;
  logic [31:0]        r_mvp_x;
  logic [31:0]        r_mvp_y;
  logic [31:0]        r_mvp_z;

  logic [15:0]        r_res_sx;
  logic [15:0]        r_res_sy;
  logic               r_res_clip;

  logic [ENTRY_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_fifo_cnt;

  logic               w_fifo_full;
  logic               w_fifo_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_is_last;
  logic               w_clip;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  logic               w_busy;
  logic               w_frame_done;
  logic               w_vert_rd;
  logic               w_mvp_start;
  logic               w_mvp_update;

  // The z result is not needed by the rasterizer.
  logic               w_unused;
  assign w_unused = ^bus.mvp_oz;

  // --------------------------------------------------------------------------
  // Shared combinational terms
  // --------------------------------------------------------------------------
  assign w_fifo_full  = (r_fifo_cnt == C_FIFO_FULL);
  assign w_fifo_valid = (r_fifo_cnt != '0);

  // Only meaningful once a non-zero count has been latched (PUSH state).
  assign w_is_last = (r_idx == (r_count - ADDR_W'(1)));

  // Screen is 640x480; anything negative or beyond the edge is clipped.
  assign w_clip = bus.mvp_ox[31]
                | ($signed(bus.mvp_ox) > 32'sd639)
                | bus.mvp_oy[31]
                | ($signed(bus.mvp_oy) > 32'sd479);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (bus.frame_start) w_state_nxt = S_UPD_ISSUE;
      S_UPD_ISSUE: if (bus.mvp_done)    w_state_nxt = S_UPD_WAIT;
      S_UPD_WAIT: begin
        if (bus.mvp_done) begin
          w_state_nxt = (r_count == '0) ? S_FINISH : S_FETCH;
        end
      end
      // FIFO space is reserved here so that PUSH can never overflow.
      S_FETCH:     if (!w_fifo_full)    w_state_nxt = S_FW1;
      S_FW1:       w_state_nxt = S_FW2;
      S_FW2:       w_state_nxt = S_XF_ISSUE;
      S_XF_ISSUE:  w_state_nxt = S_XF_WAIT;
      S_XF_WAIT:   if (bus.mvp_done)    w_state_nxt = S_PUSH;
      S_PUSH:      w_state_nxt = w_is_last ? S_FINISH : S_FETCH;
      S_FINISH:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    w_vert_rd    = 1'b0;
    w_mvp_start  = 1'b0;
    w_mvp_update = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_FINISH:    w_frame_done = 1'b1;
      S_UPD_ISSUE: begin
        w_busy = 1'b1;
        // The engine is idle between frames; the gate only holds off the
        // request if a previous operation is somehow still running.
        w_mvp_start  = bus.mvp_done;
        w_mvp_update = bus.mvp_done;
      end
      S_FETCH: begin
        w_busy    = 1'b1;
        w_vert_rd = !w_fifo_full;
      end
      S_XF_ISSUE: begin
        w_busy      = 1'b1;
        w_mvp_start = 1'b1;
      end
      default:     w_busy = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_mvp_x    <= '0;
      r_mvp_y    <= '0;
      r_mvp_z    <= '0;
      r_res_sx   <= '0;
      r_res_sy   <= '0;
      r_res_clip <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && bus.frame_start) begin
        r_count <= bus.vert_count;
      end

      if ((r_state == S_UPD_WAIT) && bus.mvp_done) begin
        r_idx <= '0;
      end else if ((r_state == S_PUSH) && !w_is_last) begin
        r_idx <= r_idx + ADDR_W'(1);
      end

      // Memory data arrives two cycles after the read strobe, i.e. in FW2.
      // The captured vertex stays put until the next FW2, covering the
      // whole transform.
      if (r_state == S_FW2) begin
        r_mvp_x <= bus.vert_x;
        r_mvp_y <= bus.vert_y;
        r_mvp_z <= bus.vert_z;
      end

      // Results are captured as the engine reports done so the FIFO entry
      // does not depend on the engine holding its outputs into PUSH.
      if ((r_state == S_XF_WAIT) && bus.mvp_done) begin
        r_res_sx   <= bus.mvp_ox[15:0];
        r_res_sy   <= bus.mvp_oy[15:0];
        r_res_clip <= w_clip;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  assign w_push      = (r_state == S_PUSH);
  assign w_pop       = w_fifo_valid && bus.out_ready;
  assign w_push_data = {r_res_sx, r_res_sy, r_res_clip, w_is_last};

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Head fields are forced to zero while empty so stale entries never leak.
  assign w_head = w_fifo_valid ? r_fifo_mem[r_rd_ptr] : '0;

  // --------------------------------------------------------------------------
  // Port drive
  // --------------------------------------------------------------------------
  assign bus.busy       = w_busy;
  assign bus.frame_done = w_frame_done;
  assign bus.vert_rd    = w_vert_rd;
  assign bus.vert_addr  = r_idx;
  assign bus.mvp_start  = w_mvp_start;
  assign bus.mvp_update = w_mvp_update;
  assign bus.mvp_x      = r_mvp_x;
  assign bus.mvp_y      = r_mvp_y;
  assign bus.mvp_z      = r_mvp_z;
  assign bus.out_valid  = w_fifo_valid;
  assign bus.out_sx     = w_head[33:18];
  assign bus.out_sy     = w_head[17:2];
  assign bus.out_clip   = w_head[1];
  assign bus.out_last   = w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_vertex_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vertex_stream_sequencer
// Purpose  : Self-checking bench for vertex_stream_sequencer. Provides a
//            vertex memory with two-cycle read latency and a projection
//            engine with random latency; predicts the rasterizer stream from
//            the per-vertex engine results and compares it entry by entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vertex_stream_sequencer;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_CYC    = 20000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vertex_stream_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  vertex_stream_sequencer #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Event counters for the current frame (stepped by the negedge monitor).
  int upd_cnt, xf_cnt, rd_cnt, fd_cnt;
  bit ov_seen;

  // Vertex memory contents and per-vertex engine results (indexed by address).
  logic [31:0] vx [256];
  logic [31:0] vy [256];
  logic [31:0] vz [256];
  int          res_ox [256];
  int          res_oy [256];

  logic [33:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the rasterizer should receive for one vertex.
  function automatic logic [33:0] model_entry(input int ox, input int oy, input bit last);
    logic [31:0] uox, uoy;
    bit clip;
    uox  = ox;
    uoy  = oy;
    clip = (ox < 0) || (ox > 639) || (oy < 0) || (oy > 479);
    return {uox[15:0], uoy[15:0], clip, last};
  endfunction

  // ---------------- vertex memory: data valid 2 cycles after vert_rd -------
  logic       p1v, p2v;
  logic [7:0] p1a, p2a;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1v <= 1'b0; p2v <= 1'b0; p1a <= '0; p2a <= '0;
    end else begin
      p1v <= bus.vert_rd; p1a <= bus.vert_addr;
      p2v <= p1v;         p2a <= p1a;
    end
  end
  assign bus.vert_x = p2v ? vx[p2a] : 32'hDEADBEEF;
  assign bus.vert_y = p2v ? vy[p2a] : 32'hDEADBEEF;
  assign bus.vert_z = p2v ? vz[p2a] : 32'hDEADBEEF;

  // ---------------- projection engine: random latency 1..4 ----------------
  logic [2:0] eng_cnt;
  logic [7:0] eng_a;
  logic       eng_xf;
  assign bus.mvp_done = (eng_cnt == 3'd0);
  assign bus.mvp_oz   = 32'd0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eng_cnt <= '0; eng_a <= '0; eng_xf <= 1'b0;
      bus.mvp_ox <= '0; bus.mvp_oy <= '0;
    end else if (bus.mvp_start) begin
      eng_cnt    <= 3'($urandom_range(4, 1));
      eng_a      <= bus.mvp_x[7:0];
      eng_xf     <= !bus.mvp_update;
      bus.mvp_ox <= 32'hBAD0BAD0;
      bus.mvp_oy <= 32'hBAD0BAD0;
    end else if (eng_cnt != 3'd0) begin
      eng_cnt <= eng_cnt - 3'd1;
      if (eng_cnt == 3'd1 && eng_xf) begin
        bus.mvp_ox <= res_ox[eng_a];
        bus.mvp_oy <= res_oy[eng_a];
      end
    end
  end

  // ---------------- negedge monitor ----------------------------------------
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.mvp_start) begin
        if (bus.mvp_update) upd_cnt++;
        else begin
          xf_cnt++;
          chk("mvp_y", bus.mvp_y, vy[bus.mvp_x[7:0]]);
          chk("mvp_z", bus.mvp_z, vz[bus.mvp_x[7:0]]);
        end
      end
      if (bus.vert_rd) begin
        chk("vert_addr", bus.vert_addr, rd_cnt);
        rd_cnt++;
      end
      if (bus.frame_done) fd_cnt++;
      if (bus.out_valid)  ov_seen = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        chk("out_entry", {bus.out_sx, bus.out_sy, bus.out_clip, bus.out_last},
            (exp_q.size() != 0) ? 64'(exp_q.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic rand_results(input int n);
    for (int i = 0; i < n; i++) begin
      res_ox[i] = int'($urandom_range(900)) - 100;
      res_oy[i] = int'($urandom_range(700)) - 100;
    end
  endtask

  task automatic start_frame(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(model_entry(res_ox[i], res_oy[i], i == n - 1));
    upd_cnt = 0; xf_cnt = 0; rd_cnt = 0; fd_cnt = 0; ov_seen = 1'b0;
    @(posedge clock); #1;
    bus.vert_count  = ADDR_W'(n);
    bus.frame_start = 1'b1;
    @(posedge clock); #1;
    bus.frame_start = 1'b0;
    chk("busy_rise", bus.busy, 1);
  endtask

  task automatic finish_frame(input int n, input bit rnd_ready, input int restart_at);
    int cyc = 0;
    while ((fd_cnt == 0 || exp_q.size() != 0) && cyc < MAX_CYC) begin
      @(posedge clock); #1;
      cyc++;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(1, 0));
      if (cyc == restart_at) begin
        bus.frame_start = 1'b1;
        bus.vert_count  = ADDR_W'(n + 3);
      end else begin
        bus.frame_start = 1'b0;
      end
    end
    bus.out_ready = 1'b1;
    chk("frame_in_time", cyc < MAX_CYC, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("frame_done_cnt", fd_cnt, 1);
    chk("upd_start_cnt", upd_cnt, 1);
    chk("xf_start_cnt", xf_cnt, n);
    chk("vert_rd_cnt", rd_cnt, n);
    chk("fifo_left", exp_q.size(), 0);
    chk("busy_end", bus.busy, 0);
    chk("out_valid_end", bus.out_valid, 0);
  endtask

  // ---------------- watchdog ------------------------------------------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence -----------------------------
  initial begin
    logic [31:0] tmp;
    int n, cyc;
    for (int a = 0; a < 256; a++) begin
      tmp = $urandom();
      vx[a] = {tmp[31:8], 8'(a)};
      vy[a] = $urandom();
      vz[a] = $urandom();
      res_ox[a] = 0;
      res_oy[a] = 0;
    end
    bus.frame_start = 1'b0;
    bus.vert_count  = '0;
    bus.out_ready   = 1'b1;
    upd_cnt = 0; xf_cnt = 0; rd_cnt = 0; fd_cnt = 0; ov_seen = 1'b0;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_vert_rd", bus.vert_rd, 0);
    chk("rst_mvp_start", bus.mvp_start, 0);
    chk("rst_mvp_update", bus.mvp_update, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_vert_addr", bus.vert_addr, 0);
    chk("rst_mvp_x", bus.mvp_x, 0);
    chk("rst_head", {bus.out_sx, bus.out_sy, bus.out_clip, bus.out_last}, 0);
    reset_n = 1'b1;

    // Empty frame: matrix update only
    start_frame(0);
    finish_frame(0, 1'b0, 0);
    chk("empty_no_out_valid", ov_seen, 0);

    // Three on-screen vertices
    for (int i = 0; i < 3; i++) begin res_ox[i] = 100 + i; res_oy[i] = 200 + i; end
    start_frame(3);
    finish_frame(3, 1'b0, 0);

    // Clipped vertex (ox=640, oy=-1)
    res_ox[0] = 10;  res_oy[0] = 20;
    res_ox[1] = 640; res_oy[1] = -1;
    start_frame(2);
    finish_frame(2, 1'b0, 0);

    // Back-pressure: FIFO fills after 4 vertices
    rand_results(6);
    bus.out_ready = 1'b0;
    start_frame(6);
    repeat (150) @(posedge clock);
    #1;
    chk("stall_vert_rd", rd_cnt, FIFO_DEPTH);
    chk("stall_xf", xf_cnt, FIFO_DEPTH);
    chk("stall_busy", bus.busy, 1);
    chk("stall_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    finish_frame(6, 1'b0, 0);

    // frame_start while busy is ignored
    rand_results(4);
    start_frame(4);
    finish_frame(4, 1'b0, 3);

    // Random frames with random back-pressure
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(12, 1));
      rand_results(n);
      start_frame(n);
      finish_frame(n, 1'b1, (k % 2 == 1) ? 5 : 0);
    end

    // Largest count: index must not wrap before the last vertex
    rand_results(255);
    start_frame(255);
    finish_frame(255, 1'b1, 0);

    // Reset in XF_WAIT
    rand_results(5);
    start_frame(5);
    cyc = 0;
    while (!(xf_cnt >= 2 && !bus.mvp_done && !bus.mvp_start) && cyc < 500) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("reach_xf_wait", cyc < 500, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_mvp_start", bus.mvp_start, 0);
    chk("midrst_vert_rd", bus.vert_rd, 0);
    chk("midrst_mvp_x", bus.mvp_x, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete();
    rand_results(3);
    start_frame(3);
    finish_frame(3, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
